// File: rtl/tt_io_out_arbiter_if.sv
// Requester-side bundle for the io_out arbiter: requests, bytes, enable mask,
// and the shared output bus with its handshake back to the requesters.
interface tt_io_out_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_i;
  logic [8*NREQ-1:0] data_i;
  logic [NREQ-1:0]   mask_i;
  logic [NREQ-1:0]   ack_o;
  logic              busy_o;
  logic [7:0]        io_out_o;

  modport master (
    output req_i, data_i, mask_i,
    input  ack_o, busy_o, io_out_o
  );

  modport slave (
    input  req_i, data_i, mask_i,
    output ack_o, busy_o, io_out_o
  );
endinterface

// File: rtl/tt_io_out_arbiter.sv
// Round-robin arbiter sharing the 8-bit tile output bus. Each grant emits a
// header word {10100, id}, then the captured data byte, each held HOLD
// cycles, followed by a single zero gap cycle.
module tt_io_out_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_io_out_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, GAP} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [2:0] LAST_ID = 3'(NREQ - 1);

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      id_q, id_d;
  logic [7:0]      dat_q, dat_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      io_out_q, io_out_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [2:0]      win_id;
  logic [7:0]      win_data;

  assign elig = bus.req_i & bus.mask_i;

  // Winner search: first eligible at or above the pointer, else the lowest
  // eligible below it (equivalent to an upward search with wrap).
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && elig[k] && (3'(k) >= ptr_q)) begin
        found  = 1'b1;
        win_id = 3'(k);
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && elig[k]) begin
        found  = 1'b1;
        win_id = 3'(k);
      end
    end
  end

  // Byte of the winning requester.
  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (3'(k) == win_id) win_data = bus.data_i[8*k +: 8];
    end
  end

  // Frame sequencing and next values of all registered outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    io_out_d = io_out_q;
    ack_d    = '0;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        io_out_d = '0;
        busy_d   = 1'b0;
        if (found) begin
          id_d     = win_id;
          dat_d    = win_data;
          ptr_d    = (win_id == LAST_ID) ? 3'd0 : win_id + 3'd1;
          cnt_d    = HOLD_M1;
          state_d  = HEADER;
          io_out_d = {5'b10100, win_id};
          busy_d   = 1'b1;
          for (int unsigned k = 0; k < NREQ; k++) begin
            ack_d[k] = (3'(k) == win_id);
          end
        end
      end
      HEADER: begin
        io_out_d = {5'b10100, id_q};
        if (cnt_q == 8'd0) begin
          state_d  = DATA;
          io_out_d = dat_q;
          cnt_d    = HOLD_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DATA: begin
        io_out_d = dat_q;
        if (cnt_q == 8'd0) begin
          state_d  = GAP;
          io_out_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        state_d  = IDLE;
        io_out_d = '0;
        busy_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      dat_q    <= '0;
      cnt_q    <= '0;
      io_out_q <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      io_out_q <= io_out_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.io_out_o = io_out_q;
  assign bus.ack_o    = ack_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_tt_io_out_arbiter.sv
// Bench for tt_io_out_arbiter: three builds (HOLD = 2, 4, 1) on one clock,
// per-cycle expectations queued at stimulus time and popped as outputs appear.
module tb_tt_io_out_arbiter;

  typedef struct packed {
    logic [7:0] io;
    logic [3:0] ack;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tt_io_out_arbiter_if #(.NREQ(4)) b2 ();
  tt_io_out_arbiter_if #(.NREQ(4)) b4 ();
  tt_io_out_arbiter_if #(.NREQ(4)) b1 ();

  tt_io_out_arbiter #(.NREQ(4), .HOLD(2)) u_h2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  tt_io_out_arbiter #(.NREQ(4), .HOLD(4)) u_h4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  tt_io_out_arbiter #(.NREQ(4), .HOLD(1)) u_h1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    b2.req_i = '0; b4.req_i = '0; b1.req_i = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    b2.mask_i = 4'hF;
    b2.data_i = 32'h0000_5C00;
    b2.req_i  = 4'b0010;
    step();
    checks++;
    if (b2.ack_o !== 4'b0010) $display("FAIL reset_pregrant: ack=%b want=0010", b2.ack_o);
    else passed++;
    // pointer now sits at 2; reset mid-frame with everyone requesting
    rst_n = 1'b0;
    b2.req_i = 4'hF;
    b2.data_i = 32'h1312_1110;
    repeat (3) sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    sb.push_back('{io: 8'hA0, ack: 4'b0001, busy: 1'b1});
    for (int n = 0; sb.size() > 0; n++) begin
      if (n == 3) rst_n = 1'b1;
      step();
      e = sb.pop_front();
      checks++;
      if ({b2.io_out_o, b2.ack_o, b2.busy_o} !== e)
        $display("FAIL reset cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b2.io_out_o, b2.ack_o, b2.busy_o, e.io, e.ack, e.busy);
      else passed++;
    end
    checks++;
    if ({b4.io_out_o, b4.ack_o, b4.busy_o, b1.io_out_o, b1.ack_o, b1.busy_o} !== 26'd0)
      $display("FAIL reset_other_builds: h4 io=%h busy=%b h1 io=%h busy=%b want 00/0",
               b4.io_out_o, b4.busy_o, b1.io_out_o, b1.busy_o);
    else passed++;
    b2.req_i = '0;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    b2.mask_i = 4'hF;
    b2.data_i = 32'h0000_5C00;
    b2.req_i  = 4'b0010;
    sb.push_back('{io: 8'hA1, ack: 4'b0010, busy: 1'b1});
    sb.push_back('{io: 8'hA1, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h5C, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h5C, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b1});
    repeat (3) sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b2.io_out_o, b2.ack_o, b2.busy_o} !== e)
        $display("FAIL single cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b2.io_out_o, b2.ack_o, b2.busy_o, e.io, e.ack, e.busy);
      else passed++;
      if (n == 0) begin
        b2.req_i  = '0;
        b2.data_i = 32'hFFFF_FFFF;
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    b2.mask_i = 4'hF;
    b2.data_i = 32'h1312_1110;
    b2.req_i  = 4'hF;
    for (int f = 0; f < 5; f++) begin
      int id;
      id = f % 4;
      sb.push_back('{io: 8'(8'hA0 + id), ack: 4'(1 << id), busy: 1'b1});
      sb.push_back('{io: 8'(8'hA0 + id), ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'(8'h10 + id), ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'(8'h10 + id), ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    end
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b2.io_out_o, b2.ack_o, b2.busy_o} !== e)
        $display("FAIL round_robin cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b2.io_out_o, b2.ack_o, b2.busy_o, e.io, e.ack, e.busy);
      else passed++;
      if (n == 28) b2.req_i = '0;
    end
  endtask

  task automatic test_masking();
    exp_t e;
    do_reset();
    b2.mask_i = 4'b1101;
    b2.data_i = 32'h0000_7700;
    b2.req_i  = 4'b0010;
    repeat (20) sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b2.io_out_o, b2.ack_o, b2.busy_o} !== e)
        $display("FAIL masked cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b2.io_out_o, b2.ack_o, b2.busy_o, e.io, e.ack, e.busy);
      else passed++;
    end
    b2.mask_i = 4'hF;
    sb.push_back('{io: 8'hA1, ack: 4'b0010, busy: 1'b1});
    sb.push_back('{io: 8'hA1, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h77, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h77, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b2.io_out_o, b2.ack_o, b2.busy_o} !== e)
        $display("FAIL unmasked cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b2.io_out_o, b2.ack_o, b2.busy_o, e.io, e.ack, e.busy);
      else passed++;
      if (n == 0) begin
        // in-flight frame must ignore all of these
        b2.req_i  = '0;
        b2.mask_i = '0;
        b2.data_i = '0;
      end
    end
    b2.mask_i = 4'hF;
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    do_reset();
    b4.mask_i = 4'hF;
    b4.data_i = 32'h00C3_0000;
    b4.req_i  = 4'b0100;
    sb.push_back('{io: 8'hA2, ack: 4'b0100, busy: 1'b1});
    repeat (3) sb.push_back('{io: 8'hA2, ack: 4'b0000, busy: 1'b1});
    repeat (2) sb.push_back('{io: 8'hC3, ack: 4'b0000, busy: 1'b1});
    sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    sb.push_back('{io: 8'hA0, ack: 4'b0001, busy: 1'b1});
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b4.io_out_o, b4.ack_o, b4.busy_o} !== e)
        $display("FAIL midframe_reset cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b4.io_out_o, b4.ack_o, b4.busy_o, e.io, e.ack, e.busy);
      else passed++;
      if (n == 0) b4.req_i = '0;
      if (n == 5) begin
        rst_n    = 1'b0;
        b4.req_i = 4'b0101;
      end
      if (n == 6) rst_n = 1'b1;
    end
    b4.req_i = '0;
  endtask

  task automatic test_hold1_back_to_back();
    exp_t e;
    do_reset();
    b1.mask_i = 4'hF;
    b1.data_i = 32'h00FF_0000;
    b1.req_i  = 4'b0100;
    repeat (2) begin
      sb.push_back('{io: 8'hA2, ack: 4'b0100, busy: 1'b1});
      sb.push_back('{io: 8'hFF, ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b1});
      sb.push_back('{io: 8'h00, ack: 4'b0000, busy: 1'b0});
    end
    for (int n = 0; sb.size() > 0; n++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({b1.io_out_o, b1.ack_o, b1.busy_o} !== e)
        $display("FAIL hold1 cyc%0d: got io=%h ack=%b busy=%b want io=%h ack=%b busy=%b",
                 n, b1.io_out_o, b1.ack_o, b1.busy_o, e.io, e.ack, e.busy);
      else passed++;
      if (n == 6) b1.req_i = '0;
    end
  endtask

  initial begin
    b2.req_i = '0; b2.data_i = '0; b2.mask_i = '0;
    b4.req_i = '0; b4.data_i = '0; b4.mask_i = '0;
    b1.req_i = '0; b1.data_i = '0; b1.mask_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_masking();
    test_midframe_reset();
    test_hold1_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
